// File: rtl/bpm_test_link_pkg.sv
// Shared BPM test link packet format: header field positions, magic and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a; both link ends import this so they agree on the wire format.
package bpm_test_link_pkg;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

   // Header word layout: {magic[7:0], bpmIndex[7:0], seq[15:0]}
   localparam int MAGIC_LSB = 24;
   localparam int IDX_LSB   = 16;
   localparam int SEQ_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_DRAIN
   } link_state_e;

   function automatic logic [7:0] hdr_magic(input logic [31:0] h);
      return h[MAGIC_LSB +: 8];
   endfunction

   function automatic logic [7:0] hdr_bpm(input logic [31:0] h);
      return h[IDX_LSB +: 8];
   endfunction

   function automatic logic [15:0] hdr_seq(input logic [31:0] h);
      return h[SEQ_LSB +: 16];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; clear has priority over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // Next count: clear wins, otherwise increment and hold at all-ones
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/read_bpm_test_link.sv
// Receive-side checker for the BPM test link: framing, sequence, payload, FA latency.
// Latency: pktGood/counters/status update on the edge that accepts tlast (visible next cycle).
// Backpressure: none; passive observer of an RX stream without tready.
module read_bpm_test_link
   import bpm_test_link_pkg::*;
#(
   parameter int         WORDS_PER_PACKET = 4,
   parameter logic [7:0] MAGIC            = MAGIC_DEFAULT,
   parameter int         COUNTER_WIDTH    = 16,
   parameter int         LATENCY_WIDTH    = 12
) (
   input  logic                     auroraUserClk,
   input  logic                     auroraResetN,
   input  logic                     auroraChannelUp,
   input  logic                     auroraFAstrobe,
   input  logic [31:0]              BPM_TEST_AXI_STREAM_RX_tdata,
   input  logic                     BPM_TEST_AXI_STREAM_RX_tvalid,
   input  logic                     BPM_TEST_AXI_STREAM_RX_tlast,
   input  logic                     csrClear,
   output logic [COUNTER_WIDTH-1:0] pktCount,
   output logic [COUNTER_WIDTH-1:0] seqErrCount,
   output logic [COUNTER_WIDTH-1:0] dataErrCount,
   output logic [COUNTER_WIDTH-1:0] lenErrCount,
   output logic [7:0]               lastBpmIndex,
   output logic [15:0]              lastSeq,
   output logic [LATENCY_WIDTH-1:0] latency,
   output logic                     pktGood
);

   localparam int              IW       = $clog2(WORDS_PER_PACKET);
   localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS_PER_PACKET - 1);

   link_state_e              state_q, state_d;
   logic [31:0]              hdr_q, hdr_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic                     bad_q, bad_d;
   logic [LATENCY_WIDTH-1:0] hdr_lat_q, hdr_lat_d;

   logic [LATENCY_WIDTH-1:0] lat_cnt_q, lat_cnt_d, lat_now;
   logic                     lat_run_q, lat_run_d;

   logic                     seq_valid_q, seq_valid_d;
   logic [7:0]               last_bpm_q, last_bpm_d;
   logic [15:0]              last_seq_q, last_seq_d;
   logic [LATENCY_WIDTH-1:0] latency_q, latency_d;
   logic                     pkt_good_q, pkt_good_d;

   logic                     good_ev, data_err_ev, len_err_ev, seq_err_ev;
   logic                     word_vld, word_last, payload_mis;
   logic [31:0]              word_dat;

   assign word_vld    = BPM_TEST_AXI_STREAM_RX_tvalid;
   assign word_last   = BPM_TEST_AXI_STREAM_RX_tlast;
   assign word_dat    = BPM_TEST_AXI_STREAM_RX_tdata;
   assign payload_mis = (word_dat != (hdr_q + 32'(idx_q)));

   // FA latency timer: lat_now is the count including this cycle, which is what a
   // header accepted now captures (so a coincident strobe still yields the old count)
   always_comb begin
      lat_now = lat_cnt_q;
      if (lat_run_q && (lat_cnt_q != '1)) begin
         lat_now = lat_cnt_q + LATENCY_WIDTH'(1);
      end
      lat_cnt_d = auroraFAstrobe ? '0 : lat_now;
      lat_run_d = lat_run_q | auroraFAstrobe;
   end

   // Framing FSM next state and per-packet error/good events (one event per packet)
   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      idx_d       = idx_q;
      bad_d       = bad_q;
      hdr_lat_d   = hdr_lat_q;
      good_ev     = 1'b0;
      data_err_ev = 1'b0;
      len_err_ev  = 1'b0;
      if (!auroraChannelUp) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_HDR;
            ST_HDR: begin
               if (word_vld) begin
                  if (word_last) begin
                     // Single-word packet: already resynchronised, wait for next header
                     len_err_ev = 1'b1;
                  end else if (hdr_magic(word_dat) != MAGIC) begin
                     data_err_ev = 1'b1;
                     state_d     = ST_DRAIN;
                  end else begin
                     hdr_d     = word_dat;
                     idx_d     = IW'(1);
                     bad_d     = 1'b0;
                     hdr_lat_d = lat_now;
                     state_d   = ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (word_vld) begin
                  if (idx_q == LAST_IDX) begin
                     if (!word_last) begin
                        len_err_ev = 1'b1;
                        state_d    = ST_DRAIN;
                     end else if (bad_q || payload_mis) begin
                        data_err_ev = 1'b1;
                        state_d     = ST_HDR;
                     end else begin
                        good_ev = 1'b1;
                        state_d = ST_HDR;
                     end
                  end else if (word_last) begin
                     len_err_ev = 1'b1;
                     state_d    = ST_HDR;
                  end else begin
                     bad_d = bad_q | payload_mis;
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (word_vld && word_last) begin
                  state_d = ST_HDR;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign seq_err_ev = good_ev && seq_valid_q &&
                       (hdr_seq(hdr_q) != (last_seq_q + 16'd1));

   // Published status for the last good packet; csrClear wins over any update
   always_comb begin
      seq_valid_d = seq_valid_q;
      last_bpm_d  = last_bpm_q;
      last_seq_d  = last_seq_q;
      latency_d   = latency_q;
      pkt_good_d  = good_ev & ~csrClear;
      if (csrClear) begin
         seq_valid_d = 1'b0;
         last_bpm_d  = '0;
         last_seq_d  = '0;
         latency_d   = '0;
      end else begin
         if (!auroraChannelUp) begin
            seq_valid_d = 1'b0;
         end
         if (good_ev) begin
            seq_valid_d = 1'b1;
            last_bpm_d  = hdr_bpm(hdr_q);
            last_seq_d  = hdr_seq(hdr_q);
            latency_d   = hdr_lat_q;
         end
      end
   end

   // State and status registers
   always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
      if (!auroraResetN) begin
         state_q     <= ST_IDLE;
         hdr_q       <= '0;
         idx_q       <= '0;
         bad_q       <= 1'b0;
         hdr_lat_q   <= '0;
         lat_cnt_q   <= '0;
         lat_run_q   <= 1'b0;
         seq_valid_q <= 1'b0;
         last_bpm_q  <= '0;
         last_seq_q  <= '0;
         latency_q   <= '0;
         pkt_good_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         idx_q       <= idx_d;
         bad_q       <= bad_d;
         hdr_lat_q   <= hdr_lat_d;
         lat_cnt_q   <= lat_cnt_d;
         lat_run_q   <= lat_run_d;
         seq_valid_q <= seq_valid_d;
         last_bpm_q  <= last_bpm_d;
         last_seq_q  <= last_seq_d;
         latency_q   <= latency_d;
         pkt_good_q  <= pkt_good_d;
      end
   end

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_pkt_cnt (
      .clk_i(auroraUserClk), .rst_ni(auroraResetN),
      .inc_i(good_ev), .clr_i(csrClear), .count_o(pktCount)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_seq_err_cnt (
      .clk_i(auroraUserClk), .rst_ni(auroraResetN),
      .inc_i(seq_err_ev), .clr_i(csrClear), .count_o(seqErrCount)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_data_err_cnt (
      .clk_i(auroraUserClk), .rst_ni(auroraResetN),
      .inc_i(data_err_ev), .clr_i(csrClear), .count_o(dataErrCount)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_len_err_cnt (
      .clk_i(auroraUserClk), .rst_ni(auroraResetN),
      .inc_i(len_err_ev), .clr_i(csrClear), .count_o(lenErrCount)
   );

   assign lastBpmIndex = last_bpm_q;
   assign lastSeq      = last_seq_q;
   assign latency      = latency_q;
   assign pktGood      = pkt_good_q;

endmodule
